// File: rtl/pipeline_ctrl.sv
// Pipeline controller: per-stage stall/flush, control registers, exception entry and EXRT return.
// Define PIPELINE_CTRL_IRQ_EN to enable the external interrupt path (IRQ_MASK/IRQ_PENDING).
`ifndef CtrlOp
`define CtrlOp             1:0
`define CTRL_OP_NOP        2'h0
`define CTRL_OP_WRCR       2'h1
`define CTRL_OP_EXRT       2'h2
`endif
`ifndef IsaExp
`define IsaExp             2:0
`define ISA_EXP_NO_EXP     3'h0
`define ISA_EXP_EXT_INT    3'h1
`define ISA_EXP_UNDEF_INSN 3'h2
`define ISA_EXP_OVERFLOW   3'h3
`define ISA_EXP_MISS_ALIGN 3'h4
`define ISA_EXP_TRAP       3'h5
`define ISA_EXP_PRV_VIO    3'h6
`endif
`ifndef CPU_KERNEL_MODE
`define CPU_KERNEL_MODE    1'b0
`define CPU_USER_MODE      1'b1
`endif

module pipeline_ctrl #(
    parameter int          IRQ_W       = 8,
    parameter logic [29:0] EXP_VEC_RST = 30'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    input  logic             mem_en,
    input  logic [29:0]      mem_pc,
    input  logic             mem_br_flag,
    input  logic [`CtrlOp]   mem_ctrl_op,
    input  logic [`IsaExp]   mem_exp_code,
    input  logic [4:0]       mem_creg_addr,
    input  logic [31:0]      mem_out,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    output logic             exe_mode,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc
);
    localparam logic [4:0] CREG_STATUS      = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS  = 5'd1;
    localparam logic [4:0] CREG_EXP_CODE    = 5'd2;
    localparam logic [4:0] CREG_EXP_VECTOR  = 5'd3;
    localparam logic [4:0] CREG_EPC         = 5'd4;
    localparam logic [4:0] CREG_IRQ_MASK    = 5'd5;
    localparam logic [4:0] CREG_IRQ_PENDING = 5'd6;

    logic           int_en, mode, pre_int_en, pre_mode;
    logic [`IsaExp] exp_code;
    logic [29:0]    exp_vector, epc;
    logic           live, irq_hit, exc_hit, int_hit, exrt_hit, wrcr_hit, wr_ok, redirect;

`ifdef PIPELINE_CTRL_IRQ_EN
    logic [IRQ_W-1:0] irq_mask;
    assign irq_hit = int_en && |(irq & ~irq_mask);
`else
    logic unused_irq;
    assign unused_irq = ^irq;
    assign irq_hit    = 1'b0;
`endif

    // Events are only taken from a valid, non-waiting MEM instruction.
    assign live     = !reset && mem_en && !mem_busy;
    assign exc_hit  = live && (mem_exp_code != `ISA_EXP_NO_EXP);
    assign int_hit  = live && !exc_hit && irq_hit;
    assign exrt_hit = live && !exc_hit && !irq_hit && (mem_ctrl_op == `CTRL_OP_EXRT);
    assign wrcr_hit = live && !exc_hit && !irq_hit && (mem_ctrl_op == `CTRL_OP_WRCR);
    assign redirect = exc_hit || int_hit || exrt_hit;
    assign exe_mode = mode;

    always_comb begin
        wr_ok = 1'b0;
        if (wrcr_hit) begin
            case (mem_creg_addr)
                CREG_STATUS, CREG_PRE_STATUS, CREG_EXP_VECTOR, CREG_EPC: wr_ok = 1'b1;
`ifdef PIPELINE_CTRL_IRQ_EN
                CREG_IRQ_MASK: wr_ok = 1'b1;
`endif
                default: wr_ok = 1'b0;
            endcase
        end
    end

    // Vector and EPC are word addresses; they read back as byte addresses.
    always_comb begin
        creg_rd_data = 32'h0;
        case (creg_rd_addr)
            CREG_STATUS:      creg_rd_data = {30'h0, int_en, mode};
            CREG_PRE_STATUS:  creg_rd_data = {30'h0, pre_int_en, pre_mode};
            CREG_EXP_CODE:    creg_rd_data = {29'h0, exp_code};
            CREG_EXP_VECTOR:  creg_rd_data = {exp_vector, 2'b00};
            CREG_EPC:         creg_rd_data = {epc, 2'b00};
`ifdef PIPELINE_CTRL_IRQ_EN
            CREG_IRQ_MASK:    creg_rd_data[IRQ_W-1:0] = irq_mask;
            CREG_IRQ_PENDING: creg_rd_data[IRQ_W-1:0] = irq;
`endif
            default:          creg_rd_data = 32'h0;
        endcase
        if (wr_ok && (mem_creg_addr == creg_rd_addr)) begin
            creg_rd_data = mem_out;
        end
    end

    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        new_pc    = 30'h0;
        if (!reset) begin
            if (mem_busy) begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
            end else if (redirect) begin
                if_flush  = 1'b1;
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
                new_pc    = exrt_hit ? epc : exp_vector;
            end else if (ld_hazard) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode       <= `CPU_KERNEL_MODE;
            int_en     <= 1'b0;
            pre_mode   <= 1'b0;
            pre_int_en <= 1'b0;
            exp_code   <= `ISA_EXP_NO_EXP;
            exp_vector <= EXP_VEC_RST;
            epc        <= 30'h0;
`ifdef PIPELINE_CTRL_IRQ_EN
            irq_mask   <= '1;
`endif
        end else if (exc_hit || int_hit) begin
            exp_code   <= exc_hit ? mem_exp_code : `ISA_EXP_EXT_INT;
            // A delay-slot instruction returns to its branch so the branch re-executes.
            epc        <= mem_br_flag ? (mem_pc - 30'd2) : (mem_pc - 30'd1);
            pre_mode   <= mode;
            pre_int_en <= int_en;
            mode       <= `CPU_KERNEL_MODE;
            int_en     <= 1'b0;
        end else if (exrt_hit) begin
            mode   <= pre_mode;
            int_en <= pre_int_en;
        end else if (wr_ok) begin
            case (mem_creg_addr)
                CREG_STATUS:     {int_en, mode} <= mem_out[1:0];
                CREG_PRE_STATUS: {pre_int_en, pre_mode} <= mem_out[1:0];
                CREG_EXP_VECTOR: exp_vector <= mem_out[31:2];
                CREG_EPC:        epc <= mem_out[31:2];
`ifdef PIPELINE_CTRL_IRQ_EN
                CREG_IRQ_MASK:   irq_mask <= mem_out[IRQ_W-1:0];
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes reference-model expectations, negedge monitor compares.
`ifndef CtrlOp
`define CtrlOp             1:0
`define CTRL_OP_NOP        2'h0
`define CTRL_OP_WRCR       2'h1
`define CTRL_OP_EXRT       2'h2
`endif
`ifndef IsaExp
`define IsaExp             2:0
`define ISA_EXP_NO_EXP     3'h0
`define ISA_EXP_EXT_INT    3'h1
`define ISA_EXP_UNDEF_INSN 3'h2
`define ISA_EXP_OVERFLOW   3'h3
`define ISA_EXP_MISS_ALIGN 3'h4
`define ISA_EXP_TRAP       3'h5
`define ISA_EXP_PRV_VIO    3'h6
`endif

module tb_pipeline_ctrl;
    localparam int          IRQ_W       = 8;
    localparam logic [29:0] EXP_VEC_RST = 30'h0;
    localparam int          W           = 71;
`ifdef PIPELINE_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [IRQ_W-1:0] irq = '0;
    logic             mem_busy = 1'b0, ld_hazard = 1'b0, mem_en = 1'b0, mem_br_flag = 1'b0;
    logic [29:0]      mem_pc = '0;
    logic [1:0]       mem_ctrl_op = '0;
    logic [2:0]       mem_exp_code = '0;
    logic [4:0]       mem_creg_addr = '0, creg_rd_addr = '0;
    logic [31:0]      mem_out = '0;
    logic [31:0]      creg_rd_data;
    logic             exe_mode;
    logic             if_stall, id_stall, ex_stall, mem_stall;
    logic             if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0]      new_pc;

    pipeline_ctrl #(.IRQ_W(IRQ_W), .EXP_VEC_RST(EXP_VEC_RST)) dut (
        .clk(clk), .reset(reset), .irq(irq), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
        .mem_en(mem_en), .mem_pc(mem_pc), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_exp_code(mem_exp_code), .mem_creg_addr(mem_creg_addr), .mem_out(mem_out),
        .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data), .exe_mode(exe_mode),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reset;
        logic [7:0]  irq;
        logic        busy, ldh, en, br;
        logic [29:0] pc;
        logic [1:0]  op;
        logic [2:0]  code;
        logic [4:0]  caddr, raddr;
        logic [31:0] out;
    } stim_t;

    logic [W-1:0] exp_q[$];
    int           n_tests = 0, n_fail = 0, cycles = 0;
    bit           done = 1'b0;

    // Architectural view of the control registers.
    logic        m_int_en, m_mode, m_pre_int_en, m_pre_mode;
    logic [2:0]  m_code;
    logic [29:0] m_vec, m_epc;
    logic [7:0]  m_mask;

    task automatic model_reset();
        m_int_en = 0; m_mode = 0; m_pre_int_en = 0; m_pre_mode = 0;
        m_code = `ISA_EXP_NO_EXP; m_vec = EXP_VEC_RST; m_epc = 0; m_mask = 8'hFF;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0: return {30'h0, m_int_en, m_mode};
            5'd1: return {30'h0, m_pre_int_en, m_pre_mode};
            5'd2: return {29'h0, m_code};
            5'd3: return {m_vec, 2'b00};
            5'd4: return {m_epc, 2'b00};
            5'd5: return IRQ_ON ? {24'h0, m_mask} : 32'h0;
            5'd6: return IRQ_ON ? {24'h0, irq} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit writable(input logic [4:0] a);
        return (a == 0) || (a == 1) || (a == 3) || (a == 4) || (IRQ_ON && a == 5);
    endfunction

    // Event: 0 none, 1 sync exception, 2 interrupt, 3 EXRT, 4 WRCR.
    task automatic model_step();
        int          ev;
        logic [3:0]  st, fl;
        logic [29:0] npc;
        logic [31:0] rd;
        ev = 0;
        if (!reset && mem_en && !mem_busy) begin
            if (mem_exp_code != `ISA_EXP_NO_EXP) ev = 1;
            else if (IRQ_ON && m_int_en && ((irq & ~m_mask) != 0)) ev = 2;
            else if (mem_ctrl_op == `CTRL_OP_EXRT) ev = 3;
            else if (mem_ctrl_op == `CTRL_OP_WRCR) ev = 4;
        end
        st = 0; fl = 0; npc = 0;
        if (!reset) begin
            if (mem_busy) st = 4'b1111;
            else if (ev >= 1 && ev <= 3) begin
                fl = 4'b1111;
                npc = (ev == 3) ? m_epc : m_vec;
            end else if (ld_hazard) begin
                st = 4'b1100;
                fl = 4'b0100;
            end
        end
        rd = m_read(creg_rd_addr);
        if (ev == 4 && writable(mem_creg_addr) && mem_creg_addr == creg_rd_addr) rd = mem_out;
        exp_q.push_back({st, fl, npc, rd, m_mode});
        if (reset) model_reset();
        else if (ev == 1 || ev == 2) begin
            m_code = (ev == 1) ? mem_exp_code : `ISA_EXP_EXT_INT;
            m_epc = mem_pc - (mem_br_flag ? 30'd2 : 30'd1);
            m_pre_int_en = m_int_en; m_pre_mode = m_mode;
            m_int_en = 0; m_mode = 0;
        end else if (ev == 3) begin
            m_int_en = m_pre_int_en; m_mode = m_pre_mode;
        end else if (ev == 4 && writable(mem_creg_addr)) begin
            case (mem_creg_addr)
                5'd0: {m_int_en, m_mode} = mem_out[1:0];
                5'd1: {m_pre_int_en, m_pre_mode} = mem_out[1:0];
                5'd3: m_vec = mem_out[31:2];
                5'd4: m_epc = mem_out[31:2];
                default: m_mask = mem_out[7:0];
            endcase
        end
    endtask

    function automatic stim_t idle(input logic [4:0] raddr);
        stim_t s;
        s.reset = 0; s.irq = 0; s.busy = 0; s.ldh = 0; s.en = 0; s.br = 0;
        s.pc = 0; s.op = `CTRL_OP_NOP; s.code = `ISA_EXP_NO_EXP;
        s.caddr = 0; s.raddr = raddr; s.out = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        reset = s.reset; irq = s.irq; mem_busy = s.busy; ld_hazard = s.ldh;
        mem_en = s.en; mem_br_flag = s.br; mem_pc = s.pc; mem_ctrl_op = s.op;
        mem_exp_code = s.code; mem_creg_addr = s.caddr; creg_rd_addr = s.raddr; mem_out = s.out;
        model_step();
    endtask

    task automatic wrcr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] raddr);
        stim_t s;
        s = idle(raddr); s.en = 1; s.op = `CTRL_OP_WRCR; s.caddr = a; s.out = d;
        drive(s);
    endtask

    task automatic trap(input logic [29:0] pc, input logic br, input logic ldh, input logic busy);
        stim_t s;
        s = idle(5'd4); s.en = 1; s.code = `ISA_EXP_TRAP; s.pc = pc; s.br = br; s.ldh = ldh; s.busy = busy;
        drive(s);
    endtask

    initial begin
        stim_t s;
        model_reset();
        s = idle(5'd3); s.reset = 1; drive(s);
        s.raddr = 5'd5; drive(s);
        s.en = 1; s.code = `ISA_EXP_TRAP; s.raddr = 5'd0; drive(s);
        drive(idle(5'd0));
        wrcr(5'd3, 32'h100, 5'd3);
        wrcr(5'd0, 32'h1, 5'd0);
        trap(30'h101, 0, 0, 0);
        drive(idle(5'd4)); drive(idle(5'd2)); drive(idle(5'd0)); drive(idle(5'd1));
        s = idle(5'd0); s.en = 1; s.op = `CTRL_OP_EXRT; drive(s);
        drive(idle(5'd0));
        trap(30'h101, 1, 0, 0);
        drive(idle(5'd4));
        wrcr(5'd5, 32'h0, 5'd5);
        wrcr(5'd0, 32'h2, 5'd0);
        s = idle(5'd2); s.en = 1; s.irq = 8'h04; drive(s);
        s = idle(5'd2); s.irq = 8'h04; drive(s);
        drive(idle(5'd4));
        trap(30'h200, 0, 0, 1);
        trap(30'h200, 0, 0, 1);
        trap(30'h200, 0, 0, 0);
        drive(idle(5'd4));
        s = idle(5'd0); s.ldh = 1; drive(s);
        trap(30'h300, 0, 1, 0);
        trap(30'h0, 0, 0, 0);
        drive(idle(5'd4));
        s = idle(5'd4); s.reset = 1; s.en = 1; s.code = `ISA_EXP_TRAP; s.pc = 30'h55; drive(s);
        drive(idle(5'd4));
        for (int i = 0; i < 600; i++) begin
            s.reset = ($urandom_range(0, 99) == 0);
            s.irq   = 8'($urandom);
            s.busy  = ($urandom_range(0, 5) == 0);
            s.ldh   = ($urandom_range(0, 4) == 0);
            s.en    = ($urandom_range(0, 3) != 0);
            s.br    = 1'($urandom);
            s.pc    = 30'($urandom);
            s.op    = 2'($urandom_range(0, 3));
            s.code  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : `ISA_EXP_NO_EXP;
            s.caddr = 5'($urandom_range(0, 7));
            s.raddr = 5'($urandom_range(0, 7));
            s.out   = $urandom;
            drive(s);
        end
        done = 1'b1;
    end

    always @(negedge clk) begin
        logic [W-1:0] got, e;
        cycles++;
        got = {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush,
               new_pc, creg_rd_data, exe_mode};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got stall=%b flush=%b new_pc=%h rd=%h mode=%b, expected stall=%b flush=%b new_pc=%h rd=%h mode=%b",
                         $time, got[70:67], got[66:63], got[62:33], got[32:1], got[0],
                         e[70:67], e[66:63], e[62:33], e[32:1], e[0]);
            end
        end else if (done) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
        if (cycles > 20000) begin
            n_fail++;
            $display("FAIL watchdog: cycles=%0d queued=%0d, expected drain before 20000", cycles, exp_q.size());
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end
endmodule
